// File: rtl/pc_return_stack_pkg.sv
// Shared CPU definitions: PC width, return-stack depth and the decoder's stack-op encoding.
package pc_return_stack_pkg;

  localparam int PC_WIDTH  = 8;
  localparam int RAS_DEPTH = 4;

  typedef enum logic [1:0] {
    OP_NOP  = 2'b00,
    OP_PUSH = 2'b01,
    OP_POP  = 2'b10,
    OP_SWAP = 2'b11
  } stack_op_e;

  // Returns {nPush, nPop}; SWAP is a call and a return in the same cycle.
  function automatic logic [1:0] stack_op_strobes(input stack_op_e op);
    return {~(op == OP_PUSH || op == OP_SWAP), ~(op == OP_POP || op == OP_SWAP)};
  endfunction

endpackage

// File: rtl/pc_return_stack.sv
// Return-address LIFO for the PC: calls store PC+1, returns drive the counter's
// parallel-load data and active-low load strobe one cycle after the pop edge.
module pc_return_stack
  import pc_return_stack_pkg::*;
#(
  parameter int WIDTH = PC_WIDTH,
  parameter int DEPTH = RAS_DEPTH,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             nReset,
  input  logic [WIDTH-1:0] pcIn,
  input  logic             nPush,
  input  logic             nPop,
  input  logic             clearErr,
  output logic [WIDTH-1:0] loadOut,
  output logic             nLoadOut,
  output logic [CW-1:0]    depth,
  output logic             empty,
  output logic             full,
  output logic             overflow,
  output logic             underflow
);

  localparam int IW = $clog2(DEPTH);

  logic [WIDTH-1:0] entry [DEPTH];
  logic             push, pop;
  logic             do_push, do_pop, do_swap;
  logic             ovf_set, unf_set;
  logic [IW-1:0]    top_idx, wr_idx;

  assign push  = ~nPush;
  assign pop   = ~nPop;
  assign empty = (depth == '0);
  assign full  = (depth == CW'(DEPTH));

  // A push+pop on a non-empty stack replaces the top in place; on an empty
  // stack the pop half is dropped and only flagged.
  assign do_swap = push & pop & ~empty;
  assign do_push = push & ~do_swap & ~full;
  assign do_pop  = pop & ~push & ~empty;
  assign ovf_set = push & ~pop & full;
  assign unf_set = pop & empty;

  assign top_idx = IW'(depth - CW'(1));
  assign wr_idx  = do_swap ? top_idx : IW'(depth);

  always_ff @(posedge clk) begin
    if (do_push | do_swap) entry[wr_idx] <= pcIn + WIDTH'(1);
  end

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      loadOut   <= '0;
      nLoadOut  <= 1'b1;
      depth     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      nLoadOut <= ~(do_pop | do_swap);
      if (do_pop | do_swap) loadOut <= entry[top_idx];
      if (do_push)     depth <= depth + CW'(1);
      else if (do_pop) depth <= depth - CW'(1);
      overflow  <= ovf_set | (overflow  & ~clearErr);
      underflow <= unf_set | (underflow & ~clearErr);
    end
  end

endmodule

// File: tb/tb_pc_return_stack.sv
// Bench for pc_return_stack: queue-based reference model checked every cycle,
// plus directed vectors with literal expectations.
module tb_pc_return_stack;

  localparam int W = 8;
  localparam int D = 4;
  localparam int CW = $clog2(D + 1);

  logic          clk = 1'b0;
  logic          nReset = 1'b0;
  logic [W-1:0]  pcIn = '0;
  logic          nPush = 1'b1, nPop = 1'b1, clearErr = 1'b0;
  logic [W-1:0]  loadOut;
  logic          nLoadOut, empty, full, overflow, underflow;
  logic [CW-1:0] depth;

  int nvec = 0;
  int nerr = 0;
  bit chk_en = 1'b0;

  pc_return_stack #(.WIDTH(W), .DEPTH(D)) dut (
    .clk(clk), .nReset(nReset), .pcIn(pcIn), .nPush(nPush), .nPop(nPop),
    .clearErr(clearErr), .loadOut(loadOut), .nLoadOut(nLoadOut), .depth(depth),
    .empty(empty), .full(full), .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  // Reference model: a plain queue of return addresses.
  int       stk[$];
  int       m_load;
  bit       m_nload, m_ovf, m_unf;

  always @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      stk.delete();
      m_load = 0; m_nload = 1; m_ovf = 0; m_unf = 0;
    end else begin
      m_nload = 1;
      if (clearErr) begin m_ovf = 0; m_unf = 0; end
      if (!nPush && !nPop && stk.size() > 0) begin
        m_load = stk.pop_back();
        stk.push_back((int'(pcIn) + 1) % 256);
        m_nload = 0;
      end else if (!nPush) begin
        if (stk.size() < D) stk.push_back((int'(pcIn) + 1) % 256);
        else m_ovf = 1;
        if (!nPop) m_unf = 1;
      end else if (!nPop) begin
        if (stk.size() > 0) begin m_load = stk.pop_back(); m_nload = 0; end
        else m_unf = 1;
      end
    end
  end

  task automatic check(input string name, input int act, input int exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("loadOut",   int'(loadOut),   m_load);
      check("nLoadOut",  int'(nLoadOut),  int'(m_nload));
      check("depth",     int'(depth),     stk.size());
      check("empty",     int'(empty),     int'(stk.size() == 0));
      check("full",      int'(full),      int'(stk.size() == D));
      check("overflow",  int'(overflow),  int'(m_ovf));
      check("underflow", int'(underflow), int'(m_unf));
    end
  end

  // Apply one cycle of inputs starting just after a posedge; returns just after the next one.
  task automatic cyc(input bit pu, input bit po, input logic [W-1:0] pc, input bit clr);
    nPush = ~pu; nPop = ~po; pcIn = pc; clearErr = clr;
    @(posedge clk); #1;
    nPush = 1'b1; nPop = 1'b1; clearErr = 1'b0;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("rst_loadOut", int'(loadOut), 0);
    check("rst_nLoadOut", int'(nLoadOut), 1);
    check("rst_depth", int'(depth), 0);
    check("rst_empty", int'(empty), 1);
    check("rst_flags", int'({overflow, underflow, full}), 0);
    nReset = 1'b1;
    chk_en = 1'b1;
    @(posedge clk); #1;

    // push/pop ordering
    cyc(1, 0, 8'h10, 0); cyc(1, 0, 8'h20, 0); cyc(1, 0, 8'h30, 0);
    check("order_depth3", int'(depth), 3);
    cyc(0, 1, 8'h00, 0);
    check("pop1", int'(loadOut), 8'h31); check("pop1_strobe", int'(nLoadOut), 0);
    cyc(0, 1, 8'h00, 0);
    check("pop2", int'(loadOut), 8'h21); check("pop2_strobe", int'(nLoadOut), 0);
    cyc(0, 1, 8'h00, 0);
    check("pop3", int'(loadOut), 8'h11); check("pop3_empty", int'(empty), 1);
    cyc(0, 0, 8'h00, 0);
    check("strobe_release", int'(nLoadOut), 1); check("hold_load", int'(loadOut), 8'h11);

    // overflow
    for (int i = 0; i < 4; i++) cyc(1, 0, W'(i), 0);
    check("full_after4", int'(full), 1); check("no_ovf_yet", int'(overflow), 0);
    cyc(1, 0, 8'h04, 0);
    check("ovf_set", int'(overflow), 1); check("ovf_depth", int'(depth), 4);
    for (int i = 4; i >= 1; i--) begin
      cyc(0, 1, 8'h00, 0);
      check("ovf_pop", int'(loadOut), i);
    end
    cyc(0, 0, 8'h00, 1);
    check("ovf_clear", int'(overflow), 0);

    // underflow and clear
    cyc(0, 1, 8'h00, 0);
    check("unf_strobe", int'(nLoadOut), 1); check("unf_set", int'(underflow), 1);
    check("unf_hold", int'(loadOut), 8'h01);
    cyc(0, 0, 8'h00, 1);
    check("unf_clear", int'(underflow), 0);
    cyc(0, 1, 8'h00, 1);
    check("unf_set_wins", int'(underflow), 1);
    cyc(0, 0, 8'h00, 1);

    // simultaneous push+pop
    cyc(1, 0, 8'h40, 0);
    cyc(1, 1, 8'h7F, 0);
    check("swap_load", int'(loadOut), 8'h41); check("swap_strobe", int'(nLoadOut), 0);
    check("swap_depth", int'(depth), 1);
    cyc(0, 1, 8'h00, 0);
    check("swap_pop", int'(loadOut), 8'h80);

    // push+pop on empty acts as push and flags underflow
    cyc(1, 1, 8'h55, 0);
    check("pp_empty_depth", int'(depth), 1); check("pp_empty_unf", int'(underflow), 1);
    check("pp_empty_strobe", int'(nLoadOut), 1);
    cyc(0, 1, 8'h00, 1);
    check("pp_empty_pop", int'(loadOut), 8'h56);

    // address wrap
    cyc(1, 0, 8'hFF, 0);
    cyc(0, 1, 8'h00, 0);
    check("wrap", int'(loadOut), 8'h00);

    // swap while full: no flags
    for (int i = 0; i < 4; i++) cyc(1, 0, W'(i), 0);
    cyc(1, 1, 8'h50, 0);
    check("swap_full_load", int'(loadOut), 8'h04);
    check("swap_full_flags", int'({overflow, underflow}), 0);
    check("swap_full_depth", int'(depth), 4);
    cyc(0, 1, 8'h00, 0);
    check("swap_full_pop", int'(loadOut), 8'h51);
    repeat (3) cyc(0, 1, 8'h00, 0);
    check("swap_full_last", int'(loadOut), 8'h01);

    // asynchronous reset mid-operation with pending strobe
    cyc(1, 0, 8'h60, 0); cyc(1, 0, 8'h61, 0); cyc(1, 0, 8'h62, 0);
    cyc(0, 0, 8'h00, 0); cyc(1, 0, 8'h00, 0); cyc(0, 0, 8'h00, 0);
    cyc(0, 1, 8'h00, 0);
    check("pre_rst_strobe", int'(nLoadOut), 0); check("pre_rst_depth", int'(depth), 3);
    nReset = 1'b0;
    #1;
    check("arst_loadOut", int'(loadOut), 0);
    check("arst_nLoadOut", int'(nLoadOut), 1);
    check("arst_depth", int'(depth), 0);
    check("arst_empty", int'(empty), 1);
    check("arst_flags", int'({overflow, underflow}), 0);
    @(posedge clk); #1;
    nReset = 1'b1;
    repeat (2) cyc(0, 0, 8'h00, 0);

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
